serial_chunk_adder: RTL and testbench

- Multi-cycle wide adder. Accepts a WIDTH-bit operand pair plus carry-in over a valid/ready handshake.
- Adds one CHUNK-bit slice per clock, LSB slice first, through a CHUNK-bit combinational adder (the team's carry-increment adder at width=CHUNK). The slice carry-out is registered and fed back as the next slice's carry-in.
- Sits directly upstream of the chunk adder. It sequences operand slices into the chunk adder and reassembles the full result.
- Used where a full-width single-cycle adder does not meet area or timing.

---
 rtl/serial_chunk_adder.sv | 118 +++++++++++
 tb/tb_serial_chunk_adder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_chunk_adder.sv
// Multi-cycle wide adder: adds one CHUNK-bit slice per clock, LSB slice first,
// rippling the slice carry through a register between cycles.
module serial_chunk_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [IDXW-1:0]  idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [CHUNK-1:0] op_a;
    logic [CHUNK-1:0] op_b;
    logic [CHUNK-1:0] raw_sum;
    logic             raw_c;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_c;

    // Chunk adder, carry-increment form: add with carry-in 0, then increment
    // the partial sum when the registered carry is set.
    always_comb begin
        op_a = a_q[idx_q*CHUNK +: CHUNK];
        op_b = b_q[idx_q*CHUNK +: CHUNK];
        {raw_c, raw_sum} = {1'b0, op_a} + {1'b0, op_b};
        chunk_sum = raw_sum + CHUNK'(carry_q);
        // An increment can only carry out when the partial sum is all ones.
        chunk_c = raw_c | (carry_q & (&raw_sum));
    end

    // Control FSM with registered handshake outputs and the slice datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        idx_q      <= '0;
                        state_q    <= StRun;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                StRun: begin
                    sum_q[idx_q*CHUNK +: CHUNK] <= chunk_sum;
                    carry_q <= chunk_c;
                    if (idx_q == LAST_IDX) begin
                        cout_q      <= chunk_c;
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Outputs come straight from registers; no path from a/b to sum.
    always_comb begin
        in_ready  = in_ready_q;
        out_valid = out_valid_q;
        sum       = sum_q;
        cout      = cout_q;
        busy      = busy_q;
    end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Self-checking bench: directed cases plus randomized back-to-back traffic
// against a plain-arithmetic reference, for CHUNK=4 and CHUNK=WIDTH instances.
module tb_serial_chunk_adder;

    localparam int W  = 32;
    localparam int N0 = 8;   // slices for CHUNK=4
    localparam int N1 = 1;   // slices for CHUNK=32

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
    logic [W-1:0]  a, b, sum;
    logic          in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, busy1;
    logic [W-1:0]  a1, b1, sum1;

    int n_tests = 0;
    int n_fail  = 0;

    serial_chunk_adder #(.WIDTH(W), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    serial_chunk_adder #(.WIDTH(W), .CHUNK(32)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic c);
        return {1'b0, x} + {1'b0, y} + {32'd0, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand pair to the CHUNK=4 instance and wait for its result.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input bit flip, output logic [32:0] res, output int lat);
        int k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        if (!in_ready) check("ready_timeout", 64'(in_ready), 64'd1);
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (flip) begin
            a = ~ta; b = ~tb; cin = ~tc;
        end
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        res = {cout, sum};
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("drain_ov", 64'(out_valid), 64'd0);
        check("drain_ir", 64'(in_ready), 64'd1);
    endtask

    // Scoreboards for the random phase, sampled mid-cycle.
    bit          rnd_on = 1'b0;
    int          cyc = 0;
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    int          acc0 = 0, acc1 = 0;
    int          last_acc0 = -100, last_acc1 = -100;
    logic        prev_ov0 = 1'b0, prev_ov1 = 1'b0;

    always @(negedge clk) cyc++;

    // CHUNK=4 scoreboard: accept interval and result ordering.
    always @(negedge clk) begin
        if (rnd_on) begin
            if (in_valid && in_ready) begin
                if (acc0 > 0) check("interval0", 64'(cyc - last_acc0 >= N0 + 2), 64'd1);
                last_acc0 = cyc;
                acc0++;
                q0.push_back(ref_add(a, b, cin));
            end
            if (out_valid && !prev_ov0) check("latency0", 64'(cyc - last_acc0), 64'(N0 + 1));
            if (out_valid && out_ready) begin
                if (q0.size() == 0) check("q0_underflow", 64'd1, 64'd0);
                else check("rand0", {31'd0, cout, sum}, 64'(q0.pop_front()));
            end
        end
        prev_ov0 = out_valid;
    end

    // CHUNK=32 scoreboard: out_valid must rise in cycle 2 after accept.
    always @(negedge clk) begin
        if (rnd_on) begin
            if (in_valid1 && in_ready1) begin
                if (acc1 > 0) check("interval1", 64'(cyc - last_acc1 >= N1 + 2), 64'd1);
                last_acc1 = cyc;
                acc1++;
                q1.push_back(ref_add(a1, b1, cin1));
            end
            if (out_valid1 && !prev_ov1) check("latency1", 64'(cyc - last_acc1), 64'(N1 + 1));
            if (out_valid1 && out_ready1) begin
                if (q1.size() == 0) check("q1_underflow", 64'd1, 64'd0);
                else check("rand1", {31'd0, cout1, sum1}, 64'(q1.pop_front()));
            end
        end
        prev_ov1 = out_valid1;
    end

    initial begin
        logic [32:0] res;
        int          lat;
        int          guard;
        bit          saw_ov;

        in_valid = 0; out_ready = 0; a = 0; b = 0; cin = 0;
        in_valid1 = 0; out_ready1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_ir", 64'(in_ready), 64'd1);
        check("rst_ov", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_res", {31'd0, cout, sum}, 64'd0);

        run_op(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, res, lat);
        check("lat_1p2", 64'(lat), 64'(N0));
        check("res_1p2", 64'(res), 64'h0_0000_0003);
        check("busy_done", 64'(busy), 64'd1);
        drain();

        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, res, lat);
        check("res_ripple", 64'(res), 64'h1_0000_0000);
        drain();

        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, res, lat);
        check("res_msb_flip", 64'(res), 64'h1_0000_0000);
        drain();

        // Reset during RUN cycle 3 abandons the op and clears cout.
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ir", 64'(in_ready), 64'd1);
        check("midrst_ov", 64'(out_valid), 64'd0);
        check("midrst_cout", 64'(cout), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        saw_ov = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) saw_ov = 1'b1;
        end
        check("midrst_no_out", 64'(saw_ov), 64'd0);
        run_op(32'd5, 32'd7, 1'b0, 1'b0, res, lat);
        check("res_5p7", 64'(res), 64'd12);
        drain();

        // Backpressure: result and flags frozen while out_ready is low.
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, res, lat);
        for (int i = 0; i < 5; i++) begin
            check("bp_res", {31'd0, cout, sum}, 64'h0_2345_6789);
            check("bp_ov", 64'(out_valid), 64'd1);
            check("bp_ir", 64'(in_ready), 64'd0);
            tick();
        end
        drain();

        // Random back-to-back traffic with in_valid held high.
        rnd_on = 1'b1;
        in_valid = 1'b1;
        in_valid1 = 1'b1;
        guard = 0;
        while (acc0 < 1000 && guard < 40000) begin
            a = $urandom; b = $urandom; cin = 1'($urandom);
            out_ready = 1'($urandom);
            a1 = $urandom; b1 = $urandom; cin1 = 1'($urandom);
            out_ready1 = 1'($urandom);
            tick();
            guard++;
        end
        check("rand_accepts", 64'(acc0 >= 1000), 64'd1);
        in_valid = 1'b0; in_valid1 = 1'b0;
        out_ready = 1'b1; out_ready1 = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        check("q0_empty", 64'(q0.size()), 64'd0);
        check("q1_empty", 64'(q1.size()), 64'd0);
        check("acc1_nonzero", 64'(acc1 > 100), 64'd1);
        rnd_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
